// File: rtl/frame_scaler_addr.sv
// frame_scaler_addr: maps the VGA raster position onto a camera frame buffer with
// integer zoom (1x/2x/4x/8x) and a movable window. Pixels outside the window show
// BORDER_COLOR. Fixed 4-edge latency from pos_x/pos_y to pixel_out.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   pos_x/pos_y  current VGA raster position
//   sync_in      {Hsync_n, Vsync_n} from the VGA driver
//   scale        zoom mode (0=1x, 1=2x, 2=4x, 3=8x), captured at (0,0)
//   off_x/off_y  window top-left corner on the display, captured at (0,0)
//   rd_addr      frame-buffer read address (registered)
//   rd_data      frame-buffer data, valid one edge after rd_addr
//   pixel_out    pixel to the VGA output
//   sync_out     sync_in delayed to align with pixel_out
//   frame_start  one-cycle pulse when pixel_out carries position (0,0)
module frame_scaler_addr #(
  parameter int unsigned    CAM_SCREEN_X = 160,
  parameter int unsigned    CAM_SCREEN_Y = 120,
  parameter int unsigned    AW           = 15,
  parameter int unsigned    DW           = 12,
  parameter logic [DW-1:0]  BORDER_COLOR = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic [1:0]    sync_in,
  input  logic [1:0]    scale,
  input  logic [9:0]    off_x,
  input  logic [9:0]    off_y,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] pixel_out,
  output logic [1:0]    sync_out,
  output logic          frame_start
);

  // Spare/black location just past the image.
  localparam int unsigned   OutAddr  = CAM_SCREEN_X * CAM_SCREEN_Y;
  localparam logic [AW-1:0] OutAddrW = AW'(OutAddr);
  localparam logic [13:0]   CamX14   = 14'(CAM_SCREEN_X);
  localparam logic [13:0]   CamY14   = 14'(CAM_SCREEN_Y);

  // Shadow copies of the window controls, only updated at (0,0).
  logic [1:0] scale_s;
  logic [9:0] off_x_s, off_y_s;

  // The (0,0) pixel itself already uses the new controls, so bypass the shadow there.
  logic       at_origin;
  logic [1:0] scale_e;
  logic [9:0] off_x_e, off_y_e;

  logic signed [10:0] dx_c, dy_c;
  logic [13:0]        lim_x, lim_y;
  logic               in_win_c;
  logic [9:0]         sx_c, sy_c;

  always_comb begin
    at_origin = (pos_x == 10'd0) && (pos_y == 10'd0);
    scale_e   = at_origin ? scale : scale_s;
    off_x_e   = at_origin ? off_x : off_x_s;
    off_y_e   = at_origin ? off_y : off_y_s;
    dx_c      = $signed({1'b0, pos_x}) - $signed({1'b0, off_x_e});
    dy_c      = $signed({1'b0, pos_y}) - $signed({1'b0, off_y_e});
    lim_x     = CamX14 << scale_e;
    lim_y     = CamY14 << scale_e;
    // Sign bit clear means dx/dy fit in 10 unsigned bits.
    in_win_c  = !dx_c[10] && !dy_c[10] &&
                ({4'd0, dx_c[9:0]} < lim_x) && ({4'd0, dy_c[9:0]} < lim_y);
    sx_c      = dx_c[9:0] >> scale_e;
    sy_c      = dy_c[9:0] >> scale_e;
  end

  // Stage 1 registers
  logic [9:0] sx_q, sy_q;
  logic       win1_q, fs1_q;
  logic [1:0] sync1_q;
  // Stage 2 side-band (address is rd_addr itself)
  logic       win2_q, fs2_q;
  logic [1:0] sync2_q;
  // Aligned with rd_data coming out of the frame buffer
  logic       win3_q, fs3_q;
  logic [1:0] sync3_q;

  // Truncation to AW bits is the intended behaviour for oversized products.
  logic [AW-1:0] addr_c;
  always_comb begin
    addr_c = AW'(sx_q) + AW'(sy_q) * AW'(CAM_SCREEN_X);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_s     <= 2'd0;
      off_x_s     <= 10'd0;
      off_y_s     <= 10'd0;
      sx_q        <= 10'd0;
      sy_q        <= 10'd0;
      win1_q      <= 1'b0;
      fs1_q       <= 1'b0;
      sync1_q     <= 2'b11;
      rd_addr     <= OutAddrW;
      win2_q      <= 1'b0;
      fs2_q       <= 1'b0;
      sync2_q     <= 2'b11;
      win3_q      <= 1'b0;
      fs3_q       <= 1'b0;
      sync3_q     <= 2'b11;
      pixel_out   <= BORDER_COLOR;
      frame_start <= 1'b0;
      sync_out    <= 2'b11;
    end else begin
      if (at_origin) begin
        scale_s <= scale;
        off_x_s <= off_x;
        off_y_s <= off_y;
      end
      // Stage 1
      sx_q        <= sx_c;
      sy_q        <= sy_c;
      win1_q      <= in_win_c;
      fs1_q       <= at_origin;
      sync1_q     <= sync_in;
      // Stage 2
      rd_addr     <= win1_q ? addr_c : OutAddrW;
      win2_q      <= win1_q;
      fs2_q       <= fs1_q;
      sync2_q     <= sync1_q;
      // Frame buffer read edge
      win3_q      <= win2_q;
      fs3_q       <= fs2_q;
      sync3_q     <= sync2_q;
      // Stage 3
      pixel_out   <= win3_q ? rd_data : BORDER_COLOR;
      frame_start <= fs3_q;
      sync_out    <= sync3_q;
    end
  end

endmodule

// File: tb/tb_frame_scaler_addr.sv
// Self-checking bench for frame_scaler_addr: random and directed positions checked
// against an arithmetic model of the window mapping and a synchronous frame buffer.
module tb_frame_scaler_addr;

  localparam int CX = 160;
  localparam int CY = 120;
  localparam int OUT_ADDR = CX * CY;
  localparam int BORDER = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pos_x, pos_y, off_x, off_y;
  logic [1:0]  sync_in, scale;
  logic [14:0] rd_addr;
  logic [11:0] rd_data;
  logic [11:0] pixel_out;
  logic [1:0]  sync_out;
  logic        frame_start;

  frame_scaler_addr dut (
    .clk         (clk),
    .rst         (rst),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .sync_in     (sync_in),
    .scale       (scale),
    .off_x       (off_x),
    .off_y       (off_y),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .pixel_out   (pixel_out),
    .sync_out    (sync_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic int pat(input int a);
    return (a * 37 + 5) & 12'hfff;
  endfunction

  // Synchronous-read frame buffer with address-derived contents.
  always @(posedge clk) rd_data <= 12'(pat(int'(rd_addr)));

  typedef struct {
    int addr;
    int pix;
    int syn;
    int fs;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   sh_s = 0, sh_ox = 0, sh_oy = 0;
  bit   rst_seen = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected mapping from the window definition, using plain division.
  function automatic exp_t model(input int px, input int py, input int sn);
    exp_t e;
    int dx, dy, z;
    bit inw;
    z   = 1 << sh_s;
    dx  = px - sh_ox;
    dy  = py - sh_oy;
    inw = dx >= 0 && dy >= 0 && dx < CX * z && dy < CY * z;
    e.addr = inw ? (dx / z) + (dy / z) * CX : OUT_ADDR;
    e.pix  = inw ? pat(e.addr) : BORDER;
    e.syn  = sn;
    e.fs   = (px == 0 && py == 0) ? 1 : 0;
    return e;
  endfunction

  // Checks outputs of the edge just passed, then presents one new position.
  task automatic step(input int px, input int py, input int sc, input int ox,
                      input int oy, input int sn, input bit r);
    exp_t e;
    if (rst_seen) begin
      check_eq("rst_rd_addr", int'(rd_addr), OUT_ADDR);
      check_eq("rst_pixel_out", int'(pixel_out), BORDER);
      check_eq("rst_sync_out", int'(sync_out), 3);
      check_eq("rst_frame_start", int'(frame_start), 0);
      rst_seen = 1'b0;
    end else if (q.size() == 4) begin
      check_eq("rd_addr", int'(rd_addr), q[2].addr);
      e = q.pop_front();
      check_eq("pixel_out", int'(pixel_out), e.pix);
      check_eq("sync_out", int'(sync_out), e.syn);
      check_eq("frame_start", int'(frame_start), e.fs);
    end
    pos_x   = 10'(px);
    pos_y   = 10'(py);
    scale   = 2'(sc);
    off_x   = 10'(ox);
    off_y   = 10'(oy);
    sync_in = 2'(sn);
    rst     = r;
    if (r) begin
      q.delete();
      sh_s = 0; sh_ox = 0; sh_oy = 0;
      rst_seen = 1'b1;
    end else begin
      if (px == 0 && py == 0) begin
        sh_s = sc; sh_ox = ox; sh_oy = oy;
      end
      q.push_back(model(px, py, sn));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pos(input int n, input int sc, input int ox, input int oy);
    for (int i = 0; i < n; i++)
      step($urandom_range(1, 799), $urandom_range(0, 524), sc, ox, oy,
           $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 3, 1'b1);
    step(0, 0, 0, 0, 0, 3, 1'b1);

    // 1x, no offset
    step(0, 0, 0, 0, 0, 0, 1'b0);
    step(5, 2, 0, 0, 0, 1, 1'b0);
    step(160, 0, 0, 0, 0, 2, 1'b0);
    step(159, 119, 0, 0, 0, 3, 1'b0);
    step(159, 120, 0, 0, 0, 0, 1'b0);
    rand_pos(300, 0, 0, 0);

    // 2x at (100,50)
    step(0, 0, 1, 100, 50, 1, 1'b0);
    step(100, 50, 1, 100, 50, 2, 1'b0);
    step(419, 289, 1, 100, 50, 3, 1'b0);
    step(420, 50, 1, 100, 50, 0, 1'b0);
    step(99, 50, 1, 100, 50, 1, 1'b0);
    step(100, 49, 1, 100, 50, 2, 1'b0);
    rand_pos(300, 1, 100, 50);

    // 8x, no offset, far corner must not wrap
    step(0, 0, 3, 0, 0, 0, 1'b0);
    step(639, 479, 3, 0, 0, 1, 1'b0);
    step(1023, 1023, 3, 0, 0, 2, 1'b0);
    rand_pos(300, 3, 0, 0);

    // Controls changed mid-frame take effect only at the next (0,0)
    step(0, 0, 0, 0, 0, 3, 1'b0);
    step(300, 200, 2, 0, 0, 0, 1'b0);
    rand_pos(200, 2, 37, 11);
    step(0, 0, 2, 0, 0, 1, 1'b0);
    step(300, 200, 2, 0, 0, 2, 1'b0);
    rand_pos(200, 2, 0, 0);

    // Fully random controls, occasional frame starts and mid-line resets
    for (int i = 0; i < 3000; i++) begin
      int px, py;
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
      if ($urandom_range(0, 49) == 0) begin px = 0; py = 0; end
      step(px, py, $urandom_range(0, 3), $urandom_range(0, 1023),
           $urandom_range(0, 1023), $urandom_range(0, 3),
           ($urandom_range(0, 199) == 0));
    end

    // Drain the pipeline
    for (int i = 0; i < 5; i++) step(700, 500, 0, 0, 0, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
